mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15; number of ACCESS cycles without mem_ready before the access is aborted; legal range 1..255.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_req, cpu_we  in  1 each  CPU (multicycle controller) access request and write select.
REQ-005 cpu_addr, cpu_wdata  in  32 each  CPU byte address and write data.
REQ-006 cpu_ack, cpu_err  out  1 each  CPU completion pulse and timeout-error flag.
REQ-007 dbg_req, dbg_we  in  1 each  debug/loader port request and write select.
REQ-008 dbg_addr, dbg_wdata  in  32 each  debug address and write data.
REQ-009 dbg_ack, dbg_err  out  1 each  debug completion pulse and timeout-error flag.
REQ-010 rdata  out  32  read data shared by both ports; valid in the ack cycle.
REQ-011 mem_en, mem_we  out  1 each  memory access strobe and write enable.
REQ-012 mem_addr, mem_wdata  out  32 each  memory address and write data.
REQ-013 mem_rdata  in  32; mem_ready  in  1  memory data and access-complete, sampled only in ACCESS.
REQ-014 owner  out  1  latched grant owner (0 = CPU, 1 = debug).
REQ-015 curr_state  out  2  state encoding for debug visibility.

Function
REQ-016 States SHALL be IDLE=2'b00, ACCESS=2'b01, DONE=2'b10; encoding 2'b11 SHALL transition to IDLE on the next edge with all strobes low.
REQ-017 IDLE: no request -> stay; exactly one request -> grant it; both requests -> grant the port not granted last (round-robin via last_grant bit).
REQ-018 On grant (IDLE->ACCESS), the arbiter SHALL latch owner, we, addr and wdata of the granted port and update last_grant; later changes on the port inputs SHALL NOT affect the access.
REQ-019 ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values; all mem_* outputs derive from registers only.
REQ-020 ACCESS with mem_ready=1: capture mem_rdata into rdata (reads only; writes leave rdata unchanged), clear error, -> DONE.
REQ-021 ACCESS: 8-bit wait counter cleared on grant and incremented each ACCESS cycle with mem_ready=0; when count reaches TIMEOUT, -> DONE with error set, rdata unchanged, mem_en low from the next cycle.
REQ-022 DONE: owner's ack=1 for exactly one cycle; owner's err=1 in the same cycle only if timed out; other port's ack/err=0; mem_en=0; -> IDLE unconditionally.
REQ-023 A requester SHALL hold req and its inputs stable until ack and deassert req on the edge ending the ack cycle; req still high in IDLE is a new request.
REQ-024 Minimum latency: req sampled in IDLE at cycle N, mem_en at N+1, ack at N+2 if mem_ready=1 at N+1; each extra wait cycle adds one.
REQ-025 A request arriving while not IDLE SHALL wait; no request is dropped, no request is granted twice per req assertion.
REQ-026 ack, err, mem_en SHALL never be asserted outside DONE/ACCESS respectively.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, mem_en=0, mem_we=0, cpu_ack=dbg_ack=0, cpu_err=dbg_err=0, owner=0, rdata=0, mem_addr=mem_wdata=0, wait counter=0, last_grant=1 (CPU wins first tie).
REQ-028 Reset asserted during ACCESS or DONE SHALL abort the access without ack; first grant after release follows REQ-017 from reset values.

Verification
REQ-029 CPU read, mem_ready high first ACCESS cycle, mem_rdata=0x8C220004 -> cpu_ack at N+2, rdata=0x8C220004, dbg_ack=0.
REQ-030 Both req high after reset -> CPU granted first (owner=0), then debug (owner=1) on next IDLE; with both held continuously, grants alternate CPU, DBG, CPU.
REQ-031 Debug write addr=0x00000040 wdata=0xDEADBEEF, mem_ready after 3 wait cycles -> mem_we=1, mem_addr/mem_wdata stable 4 ACCESS cycles, dbg_ack one cycle, rdata unchanged.
REQ-032 mem_ready held low, TIMEOUT=15 -> ACCESS lasts 15 cycles, cpu_ack=cpu_err=1 same cycle, next access with mem_ready completes with err=0.
REQ-033 rst pulsed mid-ACCESS -> mem_en low asynchronously, no ack, curr_state=00; after release, pending CPU and debug requests -> CPU granted first.
REQ-034 cpu_addr changed during ACCESS -> mem_addr keeps grant-time value until DONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU and debug ports share one memory port.
// Round-robin tie break, grant-time latching, wait-state timeout.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   cpu_req/we/addr/wdata       CPU request port
//   cpu_ack, cpu_err            CPU completion pulse and timeout flag
//   dbg_req/we/addr/wdata       debug/loader request port
//   dbg_ack, dbg_err            debug completion pulse and timeout flag
//   rdata                       read data, valid in the ack cycle
//   mem_en/we/addr/wdata        memory access strobe and payload
//   mem_rdata, mem_ready        memory read data and access-complete
//   owner                       latched grant owner (0 CPU, 1 debug)
//   curr_state                  FSM state (00 idle, 01 access, 10 done)
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        owner,
  output logic [1:0]  curr_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10,
    BAD    = 2'b11
  } state_t;

  // Last ACCESS cycle that may still wait before aborting.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        owner_q;
  logic        we_q;
  logic        err_q;
  logic        last_grant;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [7:0]  wait_cnt;
  logic        grant;
  logic        gsel;
  logic        hit;
  logic        tmo;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gsel      = 1'b0;
    hit       = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant     = 1'b1;
          // On a tie, serve whichever port did not win last time.
          gsel      = (cpu_req && dbg_req) ? ~last_grant : dbg_req;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          hit       = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_q    <= gsel;
        last_grant <= gsel;
        we_q       <= gsel ? dbg_we    : cpu_we;
        addr_q     <= gsel ? dbg_addr  : cpu_addr;
        wdata_q    <= gsel ? dbg_wdata : cpu_wdata;
        wait_cnt   <= '0;
        err_q      <= 1'b0;
      end
      if (state == ACCESS && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      if (hit) begin
        err_q <= 1'b0;
        if (!we_q)
          rdata_q <= mem_rdata;
      end
      if (tmo)
        err_q <= 1'b1;
    end
  end

  assign mem_en     = (state == ACCESS);
  assign mem_we     = (state == ACCESS) && we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rdata      = rdata_q;
  assign owner      = owner_q;
  assign curr_state = state;
  assign cpu_ack    = (state == DONE) && !owner_q;
  assign dbg_ack    = (state == DONE) && owner_q;
  assign cpu_err    = cpu_ack && err_q;
  assign dbg_err    = dbg_ack && err_q;

endmodule
